alu_seq: RTL and testbench
==========================

# alu_seq

Sequencing controller for the execution unit's combinational ALU datapath. It accepts one operation at a time over a valid/ready request port and decodes the opcode into the 8-bit ALU control word. It drives the ALU operands for one or two passes (two passes for double-width add, chaining carry through a register), captures the result and presents it on a valid/ready response port. It sits between the issue logic and the ALU inside the exec unit.

## Interface
- `DATA_WIDTH`, 16, ALU word width W; request/response data is 2W wide
- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  controller can accept request
- `req_op`  in  4  opcode (see Operation)
- `req_a`, `req_b`  in  2W  operands; single-width ops use bits [W-1:0]
- `req_cin`  in  1  carry in, used by ADDC only
- `resp_valid`  out  1  result present
- `resp_ready`  in  1  consumer takes result
- `resp_data`  out  2W  result; upper W bits 0 for single-width ops
- `resp_cout`  out  1  carry out (0 for logic ops)
- `resp_err`  out  1  illegal opcode
- `alu_a`, `alu_b`  out  W  ALU operands
- `alu_ctrl`  out  8  ALU control word
- `alu_cin`  out  1  ALU carry in
- `alu_out_en`  out  1  ALU output enable
- `alu_out`  in  W  ALU result
- `alu_cout`  in  1  ALU carry out

## Operation
- Opcodes → ctrl:
  - 0 ADD 0x2C, cin=0
  - 1 SUB 0xAC, cin=0
  - 2 AND 0x22
  - 3 OR 0x32
  - 4 XOR 0x04
  - 5 NOT(a) 0x45
  - 6 NAND 0x23
  - 7 NOR 0x33
  - 8 ADDW 0x2C, two passes
  - 9 ADDC 0x2C, cin=req_cin
  - 10–15 illegal
- Logic ops drive `alu_cin`=0.
- FSM states: IDLE, EXEC_LO, EXEC_HI, RESP.
  - IDLE: `req_ready`=1. On `req_valid`, register op and operands.
    - Legal op → EXEC_LO.
    - Illegal op → RESP with data=0, cout=0, err=1. No ALU pass occurs.
  - EXEC_LO: drive `alu_a`=a[W-1:0], `alu_b`=b[W-1:0], decoded ctrl and cin, `alu_out_en`=1.
    - Capture `alu_out` into result[W-1:0] and `alu_cout` into the carry register.
    - ADDW → EXEC_HI; otherwise → RESP.
  - EXEC_HI: drive a[2W-1:W], b[2W-1:W], ctrl 0x2C, `alu_cin`=carry register.
    - Capture result[2W-1:W] and carry → RESP.
  - RESP: `resp_valid`=1 with registered data, cout and err held stable.
    - On `resp_ready` → IDLE.
- Outside EXEC states: `alu_a`, `alu_b`, `alu_ctrl`, `alu_cin`, `alu_out_en` are all 0.
- `resp_cout`:
  - Final-pass `alu_cout` for ADD, SUB, ADDC, ADDW.
  - 0 for logic ops.
- Width rules:
  - All arithmetic is mod 2^W per pass; ADDW is mod 2^2W.
  - Single-width results zero-extend into `resp_data`.

## Timing
- Reset values: `req_ready`=0 during the reset cycle, then 1 (state IDLE). `resp_valid`, `resp_data`, `resp_cout`, `resp_err` and all `alu_*` outputs are 0.
- Request accepted on edge N (valid & ready):
  - Single-width op: EXEC_LO in cycle N..N+1; `resp_valid` rises after edge N+1.
  - ADDW: `resp_valid` rises after edge N+2.
  - Illegal op: `resp_valid` rises after edge N.
- Handshakes:
  - `req_ready` is high only in IDLE, so no accept occurs while busy. Maximum throughput is one single-width op per 3 cycles.
  - Response data is stable while `resp_valid` is high and `resp_ready` is low. No timeout.
  - Request inputs are sampled only at accept; later changes are ignored.
- Reset asserted in any state: next cycle the FSM is IDLE, outputs are at reset values, and the in-flight op is dropped with no response.

## Structure
- Package `alu_seq_pkg`: opcode enum, FSM state enum, ctrl-word localparams (`CTRL_ADD`…`CTRL_NOR`), opcode legality function.
- Sub-module `alu_seq_decode`: combinational op → {ctrl, cin_sel, wide, arith, illegal}.
- Top `alu_seq`: FSM, operand/result/carry registers, ALU drive muxing.

## Test plan
- Reset, then ADD a=0x1234, b=0x0001 → `resp_data`=0x0000_1235, cout=0, err=0. `resp_valid` 2 cycles after accept. `alu_ctrl`=0x2C for exactly one cycle.
- ADD 0xFFFF+0x0001 → data 0x0000_0000, cout=1. ADDC 0x0001+0x0001, cin=1 → 0x0003.
- ADDW a=0x0000_FFFF, b=0x0000_0001 → data 0x0001_0000, cout=0. EXEC_HI cycle has `alu_cin`=1. `resp_valid` 3 cycles after accept.
- Each logic op on a=0xF0F0, b=0xFF00: AND 0xF000, OR 0xFFF0, XOR 0x0FF0, NOT 0x0F0F, NAND 0x0FFF, NOR 0x000F; cout=0.
- Opcode 0xF → err=1, data 0, `alu_out_en` never asserted. `resp_ready` held low 5 cycles → response stable, `req_ready`=0 throughout.
- Reset asserted during EXEC_HI of an ADDW → next cycle `resp_valid`=0, `req_ready`=1, all `alu_*`=0. No response is ever emitted for that op.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencing controller.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOT  = 4'd5,
    OP_NAND = 4'd6,
    OP_NOR  = 4'd7,
    OP_ADDW = 4'd8,
    OP_ADDC = 4'd9
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC_LO = 2'd1,
    ST_EXEC_HI = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  localparam logic [7:0] CTRL_ADD  = 8'h2C;
  localparam logic [7:0] CTRL_SUB  = 8'hAC;
  localparam logic [7:0] CTRL_AND  = 8'h22;
  localparam logic [7:0] CTRL_OR   = 8'h32;
  localparam logic [7:0] CTRL_XOR  = 8'h04;
  localparam logic [7:0] CTRL_NOT  = 8'h45;
  localparam logic [7:0] CTRL_NAND = 8'h23;
  localparam logic [7:0] CTRL_NOR  = 8'h33;

  typedef struct packed {
    logic [7:0] ctrl;
    logic       cin_sel;
    logic       wide;
    logic       arith;
    logic       illegal;
  } decode_t;

  function automatic logic op_legal(input logic [3:0] op);
    return op <= 4'd9;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response handshake bundle between issue logic and the ALU sequencer.
interface alu_seq_if #(parameter int DATA_WIDTH = 16);
  logic                    req_valid;
  logic                    req_ready;
  logic [3:0]              req_op;
  logic [2*DATA_WIDTH-1:0] req_a;
  logic [2*DATA_WIDTH-1:0] req_b;
  logic                    req_cin;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [2*DATA_WIDTH-1:0] resp_data;
  logic                    resp_cout;
  logic                    resp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, req_cin, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_cout, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_cin, resp_ready,
    output req_ready, resp_valid, resp_data, resp_cout, resp_err
  );
endinterface

// File: rtl/alu_seq_decode.sv
// Opcode decode: ALU control word plus carry/width/class flags.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [3:0] op,
  output decode_t    dec
);

  always_comb begin
    dec         = '0;
    dec.illegal = !op_legal(op);
    case (op)
      OP_ADD:  begin dec.ctrl = CTRL_ADD; dec.arith = 1'b1; end
      OP_SUB:  begin dec.ctrl = CTRL_SUB; dec.arith = 1'b1; end
      OP_AND:  dec.ctrl = CTRL_AND;
      OP_OR:   dec.ctrl = CTRL_OR;
      OP_XOR:  dec.ctrl = CTRL_XOR;
      OP_NOT:  dec.ctrl = CTRL_NOT;
      OP_NAND: dec.ctrl = CTRL_NAND;
      OP_NOR:  dec.ctrl = CTRL_NOR;
      OP_ADDW: begin dec.ctrl = CTRL_ADD; dec.arith = 1'b1; dec.wide = 1'b1; end
      OP_ADDC: begin dec.ctrl = CTRL_ADD; dec.arith = 1'b1; dec.cin_sel = 1'b1; end
      default: dec.ctrl = 8'h00;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Sequences one or two passes through the external combinational ALU per request.
//   state      | meaning
//   ST_IDLE    | ready for a request
//   ST_EXEC_LO | low-word pass on the ALU
//   ST_EXEC_HI | high-word pass for ADDW, carry chained from low pass
//   ST_RESP    | result held until consumer takes it
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  alu_seq_if.slave              bus,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [7:0]            alu_ctrl,
  output logic                  alu_cin,
  output logic                  alu_out_en,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  alu_cout
);
  localparam int W = DATA_WIDTH;

  state_e          state, state_nxt;
  decode_t         dec;
  logic [2*W-1:0]  a_q, b_q, result_q;
  logic [7:0]      ctrl_q;
  logic            cin_q, wide_q, arith_q, carry_q, err_q;

  alu_seq_decode u_decode (
    .op  (bus.req_op),
    .dec (dec)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (bus.req_valid) state_nxt = dec.illegal ? ST_RESP : ST_EXEC_LO;
      ST_EXEC_LO: state_nxt = wide_q ? ST_EXEC_HI : ST_RESP;
      ST_EXEC_HI: state_nxt = ST_RESP;
      ST_RESP:    if (bus.resp_ready) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    alu_a          = '0;
    alu_b          = '0;
    alu_ctrl       = 8'h00;
    alu_cin        = 1'b0;
    alu_out_en     = 1'b0;
    case (state)
      ST_IDLE: bus.req_ready = !reset;
      ST_EXEC_LO: begin
        alu_a      = a_q[W-1:0];
        alu_b      = b_q[W-1:0];
        alu_ctrl   = ctrl_q;
        alu_cin    = cin_q;
        alu_out_en = 1'b1;
      end
      ST_EXEC_HI: begin
        alu_a      = a_q[2*W-1:W];
        alu_b      = b_q[2*W-1:W];
        alu_ctrl   = CTRL_ADD;
        alu_cin    = carry_q;
        alu_out_en = 1'b1;
      end
      ST_RESP: bus.resp_valid = 1'b1;
      default: ;
    endcase
  end

  // result_q is cleared at accept so single-width results come out zero-extended
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      ctrl_q   <= 8'h00;
      cin_q    <= 1'b0;
      wide_q   <= 1'b0;
      arith_q  <= 1'b0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (bus.req_valid) begin
          a_q      <= bus.req_a;
          b_q      <= bus.req_b;
          ctrl_q   <= dec.ctrl;
          cin_q    <= dec.cin_sel & bus.req_cin;
          wide_q   <= dec.wide;
          arith_q  <= dec.arith;
          err_q    <= dec.illegal;
          result_q <= '0;
          carry_q  <= 1'b0;
        end
        ST_EXEC_LO: begin
          result_q[W-1:0] <= alu_out;
          carry_q         <= alu_cout;
        end
        ST_EXEC_HI: begin
          result_q[2*W-1:W] <= alu_out;
          carry_q           <= alu_cout;
        end
        default: ;
      endcase
    end
  end

  assign bus.resp_data = result_q;
  assign bus.resp_cout = carry_q & arith_q;
  assign bus.resp_err  = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: behavioural ALU, arithmetic reference model, directed and random ops.
module tb_alu_seq;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [W-1:0]   alu_a, alu_b, alu_out;
  logic [7:0]     alu_ctrl;
  logic           alu_cin, alu_out_en, alu_cout;
  logic [W:0]     alu_sum;
  int             n_checks = 0;
  int             n_fail = 0;

  alu_seq_if #(.DATA_WIDTH(W)) bus ();

  alu_seq #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_cin    (alu_cin),
    .alu_out_en (alu_out_en),
    .alu_out    (alu_out),
    .alu_cout   (alu_cout)
  );

  always #5 clk = ~clk;

  // External ALU: logic ops return a parity carry so the controller must mask it
  always_comb begin
    alu_sum  = '0;
    alu_out  = '0;
    alu_cout = 1'b0;
    case (alu_ctrl)
      8'h2C: begin
        alu_sum  = (W+1)'(alu_a) + (W+1)'(alu_b) + (W+1)'(alu_cin);
        alu_out  = alu_sum[W-1:0];
        alu_cout = alu_sum[W];
      end
      8'hAC: begin
        alu_out  = alu_a - alu_b - W'(alu_cin);
        alu_cout = (W+1)'(alu_a) < ((W+1)'(alu_b) + (W+1)'(alu_cin));
      end
      8'h22: begin alu_out = alu_a & alu_b;    alu_cout = ^(alu_a ^ alu_b); end
      8'h32: begin alu_out = alu_a | alu_b;    alu_cout = ^(alu_a ^ alu_b); end
      8'h04: begin alu_out = alu_a ^ alu_b;    alu_cout = ^(alu_a ^ alu_b); end
      8'h45: begin alu_out = ~alu_a;           alu_cout = ^(alu_a ^ alu_b); end
      8'h23: begin alu_out = ~(alu_a & alu_b); alu_cout = ^(alu_a ^ alu_b); end
      8'h33: begin alu_out = ~(alu_a | alu_b); alu_cout = ^(alu_a ^ alu_b); end
      default: begin alu_out = 16'hDEAD; alu_cout = 1'b1; end
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ctrl_of(input logic [3:0] op);
    case (op)
      4'd0, 4'd8, 4'd9: return 8'h2C;
      4'd1: return 8'hAC;
      4'd2: return 8'h22;
      4'd3: return 8'h32;
      4'd4: return 8'h04;
      4'd5: return 8'h45;
      4'd6: return 8'h23;
      4'd7: return 8'h33;
      default: return 8'h00;
    endcase
  endfunction

  // Result of an operation from plain integer arithmetic
  task automatic model(input logic [3:0] op, input logic [2*W-1:0] a, input logic [2*W-1:0] b,
                       input logic cin, output logic [2*W-1:0] data, output logic cout,
                       output logic err);
    longint unsigned al, bl, s, m1, m2;
    m1 = (64'd1 << W) - 1;
    m2 = (64'd1 << (2*W)) - 1;
    al = 64'(a[W-1:0]);
    bl = 64'(b[W-1:0]);
    s = 0; data = '0; cout = 1'b0; err = 1'b0;
    case (op)
      4'd0: begin s = al + bl; data = (2*W)'(s & m1); cout = s[W]; end
      4'd1: begin data = (2*W)'((al - bl) & m1); cout = al < bl; end
      4'd2: data = (2*W)'(al & bl);
      4'd3: data = (2*W)'(al | bl);
      4'd4: data = (2*W)'(al ^ bl);
      4'd5: data = (2*W)'(~al & m1);
      4'd6: data = (2*W)'(~(al & bl) & m1);
      4'd7: data = (2*W)'(~(al | bl) & m1);
      4'd8: begin s = 64'(a) + 64'(b); data = (2*W)'(s & m2); cout = s[2*W]; end
      4'd9: begin s = al + bl + 64'(cin); data = (2*W)'(s & m1); cout = s[W]; end
      default: err = 1'b1;
    endcase
  endtask

  // Starts and ends on a falling edge with the controller idle
  task automatic run_op(input logic [3:0] op, input logic [2*W-1:0] a, input logic [2*W-1:0] b,
                        input logic cin, input int stall);
    logic [2*W-1:0]  ed;
    logic            ec, ee, lo_carry;
    int              np;
    longint unsigned lo_sum;
    model(op, a, b, cin, ed, ec, ee);
    np = (op > 4'd9) ? 0 : (op == 4'd8) ? 2 : 1;
    lo_sum = 64'(a[W-1:0]) + 64'(b[W-1:0]);
    lo_carry = lo_sum[W];
    chk("idle_alu", {alu_out_en, alu_cin, alu_ctrl, alu_a, alu_b}, 64'd0);
    chk("idle_req_ready", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_op = op;
    bus.req_a = a;
    bus.req_b = b;
    bus.req_cin = cin;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_op = 4'($urandom);
    bus.req_a = $urandom;
    bus.req_b = $urandom;
    bus.req_cin = 1'($urandom);
    for (int p = 0; p < np; p++) begin
      @(negedge clk);
      chk("exec_out_en", alu_out_en, 1);
      chk("exec_alu_a", alu_a, (p == 0) ? a[W-1:0] : a[2*W-1:W]);
      chk("exec_alu_b", alu_b, (p == 0) ? b[W-1:0] : b[2*W-1:W]);
      chk("exec_alu_ctrl", alu_ctrl, (p == 0) ? ctrl_of(op) : 8'h2C);
      chk("exec_alu_cin", alu_cin, (p == 0) ? ((op == 4'd9) ? cin : 1'b0) : lo_carry);
      chk("exec_req_ready", bus.req_ready, 0);
      chk("exec_resp_valid", bus.resp_valid, 0);
    end
    for (int s = 0; s <= stall; s++) begin
      @(negedge clk);
      chk("resp_valid", bus.resp_valid, 1);
      chk("resp_data", bus.resp_data, ed);
      chk("resp_cout", bus.resp_cout, ec);
      chk("resp_err", bus.resp_err, ee);
      chk("resp_alu_idle", {alu_out_en, alu_cin, alu_ctrl, alu_a, alu_b}, 64'd0);
      chk("resp_req_ready", bus.req_ready, 0);
      bus.resp_ready = (s == stall);
    end
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk("resp_done", bus.resp_valid, 0);
    chk("back_idle", bus.req_ready, 1);
  endtask

  initial begin
    logic [2*W-1:0] d;
    logic           c, e;
    logic [3:0]     op;
    logic [2*W-1:0] ra, rb;

    model(4'd0, 32'h1234, 32'h0001, 1'b0, d, c, e);    chk("pin_add", {e, c, d}, 34'h0_0000_1235);
    model(4'd0, 32'hFFFF, 32'h0001, 1'b0, d, c, e);    chk("pin_add_cy", {e, c, d}, 34'h1_0000_0000);
    model(4'd9, 32'h0001, 32'h0001, 1'b1, d, c, e);    chk("pin_addc", {e, c, d}, 34'h0_0000_0003);
    model(4'd8, 32'h0000_FFFF, 32'h1, 1'b0, d, c, e);  chk("pin_addw", {e, c, d}, 34'h0_0001_0000);
    model(4'd1, 32'h0000, 32'h0001, 1'b0, d, c, e);    chk("pin_sub", {e, c, d}, 34'h1_0000_FFFF);
    model(4'd5, 32'hF0F0, 32'hFF00, 1'b0, d, c, e);    chk("pin_not", {e, c, d}, 34'h0_0000_0F0F);
    model(4'd7, 32'hF0F0, 32'hFF00, 1'b0, d, c, e);    chk("pin_nor", {e, c, d}, 34'h0_0000_000F);
    model(4'hF, 32'h1234, 32'h5678, 1'b0, d, c, e);    chk("pin_illegal", {e, c, d}, 34'h2_0000_0000);

    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_cin = 1'b0;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_resp", {bus.resp_valid, bus.resp_cout, bus.resp_err, bus.resp_data}, 64'd0);
    chk("rst_alu", {alu_out_en, alu_cin, alu_ctrl, alu_a, alu_b}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(4'd0, 32'h1234, 32'h0001, 1'b0, 0);
    run_op(4'd0, 32'hFFFF, 32'h0001, 1'b0, 1);
    run_op(4'd9, 32'h0001, 32'h0001, 1'b1, 0);
    run_op(4'd8, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 0);
    for (int i = 2; i <= 7; i++) run_op(4'(i), 32'hF0F0, 32'hFF00, 1'b0, 0);
    run_op(4'hF, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 5);

    // Reset during the high pass of ADDW drops the op
    bus.req_valid = 1'b1;
    bus.req_op = 4'd8;
    bus.req_a = 32'h1234_FFFF;
    bus.req_b = 32'h0000_0001;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("hi_pass_alu_cin", {alu_out_en, alu_cin}, 2'b11);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_req_ready", bus.req_ready, 1);
    chk("rst_mid_alu", {alu_out_en, alu_cin, alu_ctrl, alu_a, alu_b}, 64'd0);
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("rst_mid_no_resp", bus.resp_valid, 0);
      @(negedge clk);
    end
    bus.resp_ready = 1'b0;

    for (int n = 0; n < 250; n++) begin
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'hFFFF_FFFF;
      if ($urandom_range(0, 7) == 0) rb = 32'h0000_FFFF;
      run_op(op, ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        chk("gap_no_resp", bus.resp_valid, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
